// File: rtl/waveform_buffer_reader_pkg.sv
// Shared types and constants for the waveform buffer reader.
package wvb_reader_pkg;
  typedef enum logic [2:0] {IDLE, POP, HWAIT, HDR, DATA, DRAIN} state_t;

  localparam int SKID_DEPTH = 4;
  // Header field positions, in units of P_ADR_WIDTH bits from the LSB.
  localparam int HDR_START_FIELD = 0;
  localparam int HDR_STOP_FIELD  = 1;
endpackage

// File: rtl/waveform_buffer_reader_if.sv
// Header hand-off and sample stream toward the downstream consumer.
interface waveform_buffer_reader_if #(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WIDTH  = 80
);
  logic [P_HDR_WIDTH-1:0]  hdr_out;
  logic                    hdr_valid;
  logic                    hdr_ready;
  logic [P_DATA_WIDTH-1:0] dout;
  logic                    dout_valid;
  logic                    dout_last;
  logic                    dout_ready;

  modport master (output hdr_out, hdr_valid, dout, dout_valid, dout_last,
                  input  hdr_ready, dout_ready);
  modport slave  (input  hdr_out, hdr_valid, dout, dout_valid, dout_last,
                  output hdr_ready, dout_ready);
endinterface

// File: rtl/waveform_buffer_reader_skid_fifo.sv
// Small skid FIFO absorbing RAM read latency while the sample stream is stalled.
module wvb_rd_skid_fifo
  import wvb_reader_pkg::*;
#(
  parameter int P_WIDTH = 23,
  parameter int P_DEPTH = SKID_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [P_WIDTH-1:0]           wr_data,
  input  logic                         rd_en,
  output logic [P_WIDTH-1:0]           rd_data,
  output logic                         empty,
  output logic [$clog2(P_DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(P_DEPTH);
  localparam int CW = $clog2(P_DEPTH+1);

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;

  // Pointers wrap naturally: depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
endmodule

// File: rtl/waveform_buffer_reader.sv
// Pops an event header, streams samples start..stop (wrapping) from the waveform buffer.
// Optional WVB_READER_EOE_CHECK_EN: sticky eoe_err when a sample's bit 0 disagrees with dout_last.
module waveform_buffer_reader
  import wvb_reader_pkg::*;
#(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_HDR_LAT    = 2,
  parameter int P_RAM_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hdr_empty,
  output logic                    hdr_rdreq,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data_in,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_data_in,
  output logic                    busy,
  output logic                    eoe_err,
  waveform_buffer_reader_if.master strm
);
  localparam int ST  = P_RAM_LAT;
  localparam int HCW = (P_HDR_LAT > 1) ? $clog2(P_HDR_LAT) : 1;
  localparam int FW  = P_DATA_WIDTH + 1;

  state_t                      state, nxt;
  logic [HCW-1:0]              hwait_cnt;
  logic [P_HDR_WIDTH-1:0]      hdr_q;
  logic [ST:1]                 vld_pipe, last_pipe;
  logic [P_ADR_WIDTH-1:0]      start_addr, stop_addr;
  logic                        hwait_done, hdr_valid, hdr_acc, issue, issue_last, xfer;
  logic [FW-1:0]               fifo_q;
  logic                        fifo_empty;
  logic [$clog2(SKID_DEPTH+1)-1:0] fifo_count;
  int                          inflight;

  assign start_addr = hdr_q[HDR_START_FIELD*P_ADR_WIDTH +: P_ADR_WIDTH];
  assign stop_addr  = hdr_q[HDR_STOP_FIELD*P_ADR_WIDTH +: P_ADR_WIDTH];
  assign hwait_done = (hwait_cnt == HCW'(P_HDR_LAT-1));
  assign hdr_acc    = hdr_valid && strm.hdr_ready;
  assign issue_last = (wvb_rd_addr == stop_addr);

  // Credit check counts reads still in the RAM pipe plus samples already parked.
  always_comb begin
    inflight = 0;
    for (int k = 1; k <= ST; k++) inflight = inflight + int'(vld_pipe[k]);
  end
  assign issue = (state == DATA) && ((inflight + int'(fifo_count)) < SKID_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    hdr_rdreq = 1'b0;
    hdr_valid = 1'b0;
    case (state)
      IDLE:    if (!hdr_empty) nxt = POP;
      POP:     begin hdr_rdreq = 1'b1; nxt = HWAIT; end
      HWAIT:   if (hwait_done) nxt = HDR;
      HDR:     begin hdr_valid = 1'b1; if (strm.hdr_ready) nxt = DATA; end
      DATA:    if (issue && issue_last) nxt = DRAIN;
      DRAIN:   if (xfer && strm.dout_last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwait_cnt   <= '0;
      hdr_q       <= '0;
      wvb_rd_addr <= '0;
      vld_pipe    <= '0;
      last_pipe   <= '0;
    end else begin
      if (state == POP)        hwait_cnt <= '0;
      else if (state == HWAIT) hwait_cnt <= hwait_cnt + 1'b1;
      if (state == HWAIT && hwait_done) hdr_q <= hdr_data_in;
      if (hdr_acc)    wvb_rd_addr <= start_addr;
      else if (issue) wvb_rd_addr <= wvb_rd_addr + 1'b1;
      vld_pipe[1]  <= issue;
      last_pipe[1] <= issue && issue_last;
      for (int k = 2; k <= ST; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        last_pipe[k] <= last_pipe[k-1];
      end
    end
  end

  wvb_rd_skid_fifo #(.P_WIDTH(FW), .P_DEPTH(SKID_DEPTH)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (vld_pipe[ST]),
    .wr_data ({last_pipe[ST], wvb_data_in}),
    .rd_en   (xfer),
    .rd_data (fifo_q),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign strm.dout_valid = !fifo_empty;
  assign strm.dout       = fifo_empty ? '0 : fifo_q[P_DATA_WIDTH-1:0];
  assign strm.dout_last  = !fifo_empty && fifo_q[P_DATA_WIDTH];
  assign strm.hdr_valid  = hdr_valid;
  assign strm.hdr_out    = hdr_q;
  assign xfer            = strm.dout_valid && strm.dout_ready;
  assign busy            = (state != IDLE);

`ifdef WVB_READER_EOE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  eoe_err <= 1'b0;
    else if (xfer && (strm.dout[0] != strm.dout_last)) eoe_err <= 1'b1;
  end
`else
  assign eoe_err = 1'b0;
`endif
endmodule

// File: doc/waveform_buffer_reader.md
WAVEFORM_BUFFER_READER -- requirements
Module: waveform_buffer_reader

Interface
REQ-001 SHALL have parameters: P_DATA_WIDTH, 22, sample word width (bit 0 = end-of-event flag); P_ADR_WIDTH, 12, buffer address width; P_HDR_WIDTH, 80, header width; P_HDR_LAT, 2, cycles from hdr_rdreq to valid hdr_data_in; P_RAM_LAT, 1, cycles from wvb_rd_addr to valid wvb_data_in.
REQ-002 SHALL have ports: clk in 1 sole clock; rst_n in 1 reset, asynchronous, active-low; hdr_empty in 1 header FIFO empty; hdr_rdreq out 1 header pop; hdr_data_in in P_HDR_WIDTH popped header; wvb_rd_addr out P_ADR_WIDTH buffer read address; wvb_data_in in P_DATA_WIDTH buffer read data.
REQ-003 SHALL have ports: hdr_out out P_HDR_WIDTH captured header; hdr_valid out 1 header available; hdr_ready in 1 header accepted; dout out P_DATA_WIDTH sample; dout_valid out 1; dout_last out 1 final sample of event; dout_ready in 1; busy out 1 event in progress; eoe_err out 1 sticky end-of-event mismatch.

Function
REQ-004 Header fields SHALL be: start address hdr[P_ADR_WIDTH-1:0], stop address hdr[2*P_ADR_WIDTH-1:P_ADR_WIDTH]; remaining bits passed through unmodified.
REQ-005 FSM states SHALL be IDLE, POP, HWAIT, HDR, DATA, DRAIN.
REQ-006 IDLE->POP when hdr_empty=0; POP asserts hdr_rdreq for exactly one cycle, then HWAIT for P_HDR_LAT cycles; header captured into hdr_out on the last HWAIT cycle; ->HDR.
REQ-007 HDR: hdr_valid=1 until hdr_valid&hdr_ready; then ->DATA with read address = start.
REQ-008 Sample count SHALL be ((stop - start) mod 2^P_ADR_WIDTH) + 1; address increments modulo 2^P_ADR_WIDTH (wrap from max to 0); start==stop yields one sample.
REQ-009 DATA: one address issued per cycle while skid FIFO credits remain (in-flight + stored < 4); moves to DRAIN after stop address issued.
REQ-010 Output stream SHALL obey valid/ready: dout, dout_last stable while dout_valid=1 and dout_ready=0; no sample dropped or duplicated.
REQ-011 dout_last SHALL be 1 exactly on the sample read from stop address.
REQ-012 DRAIN->IDLE on the dout_last transfer; hdr_rdreq never asserted outside POP; at most one event in flight.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 With dout_ready held 1, throughput SHALL be one sample per cycle after P_RAM_LAT fill.

Reset
REQ-015 rst_n low SHALL asynchronously force IDLE, hdr_rdreq=0, hdr_valid=0, dout_valid=0, dout_last=0, busy=0, eoe_err=0, wvb_rd_addr=0, hdr_out=0, dout=0, skid FIFO empty.
REQ-016 Reset mid-event SHALL abandon the event; the popped header is lost; no further hdr_rdreq until one cycle after rst_n deasserts.

Configuration
REQ-017 With WVB_READER_EOE_CHECK_EN defined: eoe_err sets (sticky until reset) when a sample's bit 0 differs from dout_last on that sample's output transfer.
REQ-018 Without WVB_READER_EOE_CHECK_EN: eoe_err tied 0; no check logic.

Structure
REQ-019 Shared package wvb_reader_pkg SHALL hold FSM state enum, skid depth constant (4), and header field offset constants.
REQ-020 Sub-module wvb_rd_skid_fifo (depth 4, width P_DATA_WIDTH+1) SHALL absorb RAM latency under backpressure.

Verification
REQ-021 start=0x010, stop=0x013, dout_ready=1 -> 4 samples, addresses 0x010..0x013, dout_last on 4th, one hdr_rdreq pulse.
REQ-022 start=0xFFE, stop=0x001 -> 4 samples from 0xFFE,0xFFF,0x000,0x001; dout_last on 0x001.
REQ-023 start=stop=0x200 -> one sample with dout_last=1; return to IDLE.
REQ-024 dout_ready toggled 1/0 randomly over 64-sample event -> all 64 in order, none lost, dout stable while stalled.
REQ-025 Two headers queued, hdr_ready delayed 5 cycles -> second hdr_rdreq only after first dout_last transfer.
REQ-026 rst_n low mid-DATA -> all outputs at reset values immediately; with macro, sample bit0=1 at non-stop address -> eoe_err=1 and held.
